// File: rtl/instr_sequencer.sv
// ============================================================================
// Module  : instr_sequencer
// Purpose : Fetches 20-bit program words over req/ack, issues ALU inst/b and
//           executes JC/JMP/HALT. Optional macro: FETCH_TIMEOUT_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module instr_sequencer #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        carry,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [19:0] mem_rdata,
   output logic [3:0]  inst,
   output logic [15:0] b,
   output logic        issue,
   output logic        halted,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_EXEC   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam logic [3:0] OP_JC   = 4'hD;
   localparam logic [3:0] OP_JMP  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("instr_sequencer: TIMEOUT must be at least 1");
   end

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [19:0] ir_q, ir_d;
   logic        mem_req_q, mem_req_d;
   logic [3:0]  inst_q, inst_d;
   logic [15:0] b_q, b_d;
   logic        issue_q, issue_d;
   logic        halted_q, halted_d;
   logic [3:0]  ir_op;
   logic [15:0] ir_imm;

`ifdef FETCH_TIMEOUT_EN
   localparam int              CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] tcnt_q, tcnt_d;
   logic             err_q, err_d;
`endif

   assign ir_op  = ir_q[19:16];
   assign ir_imm = ir_q[15:0];

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      mem_req_d = mem_req_q;
      inst_d    = inst_q;
      b_d       = b_q;
      issue_d   = 1'b0;
      halted_d  = halted_q;
`ifdef FETCH_TIMEOUT_EN
      tcnt_d    = tcnt_q;
      err_d     = err_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_FETCH;
               mem_req_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
               tcnt_d    = '0;
`endif
            end
         end

         S_FETCH: begin
            // An ack on the same edge the wait budget runs out still wins.
            if (mem_ack) begin
               ir_d      = mem_rdata;
               mem_req_d = 1'b0;
               state_d   = S_EXEC;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (tcnt_q == CNT_LAST) begin
               err_d     = 1'b1;
               halted_d  = 1'b1;
               mem_req_d = 1'b0;
               state_d   = S_HALTED;
            end else begin
               tcnt_d = tcnt_q + CNT_W'(1);
            end
`endif
         end

         S_EXEC: begin
            state_d   = S_FETCH;
            mem_req_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
            tcnt_d    = '0;
`endif
            case (ir_op)
               OP_JC: begin
                  pc_d = carry ? ir_imm : (pc_q + 16'd1);
               end
               OP_JMP: begin
                  pc_d = ir_imm;
               end
               OP_HALT: begin
                  halted_d  = 1'b1;
                  mem_req_d = 1'b0;
                  state_d   = S_HALTED;
               end
               default: begin
                  inst_d  = ir_op;
                  b_d     = ir_imm;
                  issue_d = 1'b1;
                  pc_d    = pc_q + 16'd1;
               end
            endcase
         end

         S_HALTED: begin
            state_d = S_HALTED;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pc_q      <= 16'd0;
         ir_q      <= 20'd0;
         mem_req_q <= 1'b0;
         inst_q    <= 4'd0;
         b_q       <= 16'd0;
         issue_q   <= 1'b0;
         halted_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         tcnt_q    <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         mem_req_q <= mem_req_d;
         inst_q    <= inst_d;
         b_q       <= b_d;
         issue_q   <= issue_d;
         halted_q  <= halted_d;
`ifdef FETCH_TIMEOUT_EN
         tcnt_q    <= tcnt_d;
         err_q     <= err_d;
`endif
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = pc_q;
   assign inst     = inst_q;
   assign b        = b_q;
   assign issue    = issue_q;
   assign halted   = halted_q;
`ifdef FETCH_TIMEOUT_EN
   assign err      = err_q;
`else
   assign err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// Module  : tb_instr_sequencer
// Purpose : Directed program runs against an instruction-level model of the
//           sequencer, plus hand-computed spot values.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_sequencer;

   localparam int TB_TIMEOUT = 15;
   localparam int MAXC       = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        carry = 1'b0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [19:0] mem_rdata = 20'd0;
   logic [3:0]  inst;
   logic [15:0] b;
   logic        issue;
   logic        halted;
   logic        err;

   instr_sequencer #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .carry     (carry),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .inst      (inst),
      .b         (b),
      .issue     (issue),
      .halted    (halted),
      .err       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Program memory with a configurable number of wait cycles per fetch.
   logic [19:0] prog [0:65535];
   int          wait_cycles = 0;
   bit          ack_force = 1'b0;
   int          wcnt = 0;

   always @(negedge clk) begin
      if (ack_force) begin
         mem_ack   = 1'b1;
         mem_rdata = prog[mem_addr];
      end else if (mem_req) begin
         if (wcnt >= wait_cycles) begin
            mem_ack   = 1'b1;
            mem_rdata = prog[mem_addr];
         end else begin
            mem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         mem_ack = 1'b0;
         wcnt    = 0;
      end
   end

   int n_pass = 0;
   int n_total = 0;

   logic [39:0] exp_v [0:MAXC-1];
   logic [39:0] got_v [0:MAXC-1];

   function automatic logic [39:0] pack(logic r, logic [15:0] a, logic i,
                                        logic [3:0] in, logic [15:0] bb,
                                        logic h, logic e);
      return {r, a, i, in, bb, h, e};
   endfunction

   function automatic logic [39:0] sample_dut();
      return {mem_req, mem_addr, issue, inst, b, halted, err};
   endfunction

   task automatic check_vec(input string name, input int c,
                            input logic [39:0] g, input logic [39:0] e);
      n_total++;
      if (g === e) n_pass++;
      else
         $display("FAIL %s cyc %0d: got req=%0b addr=%h issue=%0b inst=%h b=%h halted=%0b err=%0b, expected req=%0b addr=%h issue=%0b inst=%h b=%h halted=%0b err=%0b",
                  name, c, g[39], g[38:23], g[22], g[21:18], g[17:2], g[1], g[0],
                  e[39], e[38:23], e[22], e[21:18], e[17:2], e[1], e[0]);
   endtask

   task automatic chk(input string name, input int g, input int e);
      n_total++;
      if (g == e) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, g, e);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 65536; i++) prog[i] = 20'hF0000;
   endtask

   // Walks the program one instruction at a time: each instruction costs
   // (wait+1) fetch cycles with req high, then one execute cycle; its effect
   // is visible from the first fetch cycle of the next instruction.
   task automatic build_model(input int n);
      int          t;
      logic [15:0] pc;
      logic [3:0]  mi;
      logic [15:0] mb;
      bit          iss, hlt, er, tmo;
      int          fc;
      logic [19:0] w;
      t = 0; pc = 16'd0; mi = 4'd0; mb = 16'd0; iss = 0; hlt = 0; er = 0;
      while (t < n) begin
         if (hlt) begin
            exp_v[t] = pack(1'b0, pc, 1'b0, mi, mb, 1'b1, er);
            t++;
         end else begin
            fc  = wait_cycles + 1;
            tmo = 0;
`ifdef FETCH_TIMEOUT_EN
            if (wait_cycles >= TB_TIMEOUT) begin
               fc  = TB_TIMEOUT;
               tmo = 1;
            end
`endif
            for (int k = 0; k < fc && t < n; k++) begin
               exp_v[t] = pack(1'b1, pc, iss, mi, mb, 1'b0, 1'b0);
               iss = 0;
               t++;
            end
            if (tmo) begin
               hlt = 1;
               er  = 1;
            end else if (t < n) begin
               w = prog[pc];
               exp_v[t] = pack(1'b0, pc, 1'b0, mi, mb, 1'b0, 1'b0);
               t++;
               if (w[19:16] <= 4'hC) begin
                  mi  = w[19:16];
                  mb  = w[15:0];
                  iss = 1;
                  pc  = pc + 16'd1;
               end else if (w[19:16] == 4'hD) begin
                  pc = carry ? w[15:0] : pc + 16'd1;
               end else if (w[19:16] == 4'hE) begin
                  pc = w[15:0];
               end else begin
                  hlt = 1;
               end
            end
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_vec("reset_state", 0, sample_dut(), 40'd0);
      reset = 1'b0;
   endtask

   task automatic run_cycles(input string name, input int n, input bit poke);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < n; c++) begin
         if (c > 0) @(negedge clk);
         got_v[c] = sample_dut();
         check_vec(name, c, got_v[c], exp_v[c]);
         if (poke) begin
            start     = (c >= 6 && c < 8);
            ack_force = (c >= 6 && c < 9);
         end
      end
      start     = 1'b0;
      ack_force = 1'b0;
   endtask

   task automatic run_test(input string name, input int n, input bit poke);
      do_reset();
      build_model(n);
      run_cycles(name, n, poke);
   endtask

   task automatic load_loop_prog();
      clear_prog();
      prog[0] = 20'h1000A;
      prog[1] = 20'h20003;
      prog[2] = 20'hE0000;
   endtask

   initial begin
      repeat (2) @(negedge clk);

      // Single ALU op then HALT; start/ack poked while halted.
      clear_prog();
      prog[0] = 20'h0000A;
      prog[1] = 20'hF0000;
      wait_cycles = 0;
      run_test("alu_halt", 10, 1'b1);
      chk("alu_halt issue@2", got_v[2][22], 1);
      chk("alu_halt inst@2", got_v[2][21:18], 0);
      chk("alu_halt b@2", got_v[2][17:2], 10);
      chk("alu_halt halted@6", got_v[6][1], 1);
      chk("alu_halt addr@6", got_v[6][38:23], 1);
      chk("alu_halt req@9", got_v[9][39], 0);

      // Loop program, zero-wait.
      load_loop_prog();
      run_test("loop0", 20, 1'b0);
      chk("loop0 inst@2", got_v[2][21:18], 1);
      chk("loop0 b@4", got_v[4][17:2], 3);
      chk("loop0 issue@4", got_v[4][22], 1);
      chk("loop0 addr@6", got_v[6][38:23], 0);
      chk("loop0 issue@6", got_v[6][22], 0);
      chk("loop0 issue@8", got_v[8][22], 1);

      // JC taken / not taken.
      clear_prog();
      prog[0] = 20'h10001;
      prog[1] = 20'h20002;
      prog[2] = 20'hD0005;
      carry = 1'b1;
      run_test("jc_taken", 10, 1'b0);
      chk("jc_taken addr@6", got_v[6][38:23], 5);
      chk("jc_taken issue@6", got_v[6][22], 0);
      carry = 1'b0;
      run_test("jc_not", 10, 1'b0);
      chk("jc_not addr@6", got_v[6][38:23], 3);
      chk("jc_not issue@6", got_v[6][22], 0);

      // Three wait cycles per fetch.
      load_loop_prog();
      wait_cycles = 3;
      run_test("wait3", 30, 1'b0);
      chk("wait3 req@3", got_v[3][39], 1);
      chk("wait3 req@4", got_v[4][39], 0);
      chk("wait3 issue@5", got_v[5][22], 1);
      chk("wait3 b@9", got_v[9][17:2], 10);
      chk("wait3 issue@10", got_v[10][22], 1);
      chk("wait3 inst@10", got_v[10][21:18], 2);

      // Reset in the middle of a fetch, then restart from pc 0.
      wait_cycles = 5;
      do_reset();
      build_model(3);
      run_cycles("midfetch", 3, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check_vec("midfetch_reset", 0, sample_dut(), 40'd0);
      reset = 1'b0;
      wait_cycles = 0;
      build_model(12);
      run_cycles("refetch", 12, 1'b0);
      chk("refetch addr@0", got_v[0][38:23], 0);
      chk("refetch issue@2", got_v[2][22], 1);

      // 16 wait cycles: waits forever by default, times out with the option.
      clear_prog();
      prog[0] = 20'h41234;
      wait_cycles = 16;
      run_test("wait16", 24, 1'b0);
`ifdef FETCH_TIMEOUT_EN
      chk("tmo req@14", got_v[14][39], 1);
      chk("tmo err@15", got_v[15][0], 1);
      chk("tmo halted@15", got_v[15][1], 1);
      chk("tmo req@15", got_v[15][39], 0);
`else
      chk("wait16 req@16", got_v[16][39], 1);
      chk("wait16 issue@18", got_v[18][22], 1);
      chk("wait16 b@18", got_v[18][17:2], 16'h1234);
      chk("wait16 err@20", got_v[20][0], 0);
`endif

      // Ack in the 15th fetch cycle is a normal fetch.
      wait_cycles = 14;
      run_test("wait14", 20, 1'b0);
      chk("wait14 issue@16", got_v[16][22], 1);
      chk("wait14 inst@16", got_v[16][21:18], 4);
      chk("wait14 err@16", got_v[16][0], 0);

      // pc wrap from 0xFFFF to 0x0000.
      clear_prog();
      prog[0]     = 20'hEFFFF;
      prog[16'hFFFF] = 20'h30007;
      wait_cycles = 0;
      run_test("wrap", 12, 1'b0);
      chk("wrap addr@2", got_v[2][38:23], 16'hFFFF);
      chk("wrap addr@4", got_v[4][38:23], 0);
      chk("wrap issue@4", got_v[4][22], 1);
      chk("wrap b@4", got_v[4][17:2], 7);

      // JMP to itself loops forever without issuing.
      clear_prog();
      prog[0] = 20'hE0000;
      run_test("jmp_self", 8, 1'b0);
      chk("jmp_self addr@6", got_v[6][38:23], 0);
      chk("jmp_self issue@6", got_v[6][22], 0);
      chk("jmp_self halted@7", got_v[7][1], 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
